ads1292_sample_packer: RTL and testbench
========================================

Name: ads1292_sample_packer

Overview:
- Upstream of the integer-to-float converter in the ADS1292 filter path.
- Assembles the 9-byte ADS1292 read-data frame (3 status bytes, 3 CH1 bytes, 3 CH2 bytes) delivered byte-wise by the SPI engine.
- Selects one channel, sign-extends its 24-bit two's-complement sample to 32 bits, and offers it on a STB/ACK output handshake that connects directly to the converter's i_A/i_A_STB/o_A_ACK.

Parameters:
- BYTE_TIMEOUT, 1024: idle clock cycles allowed between bytes inside a frame before the partial frame is aborted (range 2..65535).
- SYNC_NIBBLE, 4'hC: required value of status byte 0 bits [7:4].

Ports:
- i_CLK  in  1  clock
- i_RSTN  in  1  reset, asynchronous, active-low
- i_BYTE  in  8  received SPI byte
- i_BYTE_STB  in  1  one-cycle strobe; i_BYTE is valid
- i_FRAME_START  in  1  high together with i_BYTE_STB on the first byte of a frame
- i_CH_SEL  in  1  0 = CH1, 1 = CH2; sampled when byte 8 is accepted
- i_OVR_CLR  in  1  clears o_OVERRUN
- o_Z  out  32  sign-extended sample
- o_Z_STB  out  1  o_Z valid
- i_Z_ACK  in  1  downstream accepts o_Z
- o_STATUS  out  24  status word of the last good frame
- o_FRAME_ERR  out  1  one-cycle pulse; frame discarded
- o_OVERRUN  out  1  sticky; a completed sample was dropped

Behaviour:
- Reset (async, i_RSTN=0):
  - Collector FSM = IDLE; byte count = 0; timeout counter = 0.
  - o_Z = 0, o_Z_STB = 0, o_STATUS = 0, o_FRAME_ERR = 0, o_OVERRUN = 0.
- Collector FSM states: IDLE, COLLECT.
  - IDLE: waits for i_BYTE_STB && i_FRAME_START.
    - Stores the byte as byte 0, sets count = 1, goes to COLLECT.
    - A strobe without i_FRAME_START is ignored.
  - COLLECT: each i_BYTE_STB stores i_BYTE at index count and increments count.
    - i_BYTE_STB && i_FRAME_START in COLLECT: pulse o_FRAME_ERR, restart the frame with this byte as byte 0 (count = 1).
    - No i_BYTE_STB for BYTE_TIMEOUT consecutive cycles: pulse o_FRAME_ERR, return to IDLE. The timeout counter clears on every strobe.
    - Byte 8 accepted (count was 8): return to IDLE, then run the completion check below.
- Completion check:
  - byte0[7:4] != SYNC_NIBBLE: pulse o_FRAME_ERR, no sample produced.
  - Otherwise: o_STATUS <= {b0,b1,b2}. Sample = i_CH_SEL ? {b6,b7,b8} : {b3,b4,b5}. Candidate o_Z = {{8{sample[23]}}, sample}.
- Output stage (single register, no FIFO):
  - Free slot: on the cycle after byte 8 is accepted, o_Z updates and o_Z_STB = 1.
  - o_Z_STB stays high and o_Z stays stable until the cycle after o_Z_STB && i_Z_ACK, when o_Z_STB drops to 0.
  - Slot still full at completion (o_Z_STB=1 and no ACK on that cycle): keep the old o_Z, drop the new sample, set o_OVERRUN = 1. o_STATUS still updates.
  - ACK on the same cycle as completion: the slot counts as free and the new sample loads. o_Z_STB remains 1 with the new value.
- Collection continues while the output slot is full. Bytes are never back-pressured.
- i_OVR_CLR has priority over a simultaneous set: o_OVERRUN = 0.
- Latency: byte-8 strobe edge to o_Z_STB high = 1 cycle.
- Reset mid-frame discards partial data. The first post-reset frame must begin with i_FRAME_START.

Optional Feature:
- Macro: ADS1292_PACKER_LOFF_EN.
- Defined: after a good frame, examine lead-off status bits.
  - CH1 selected: check status bits [15:16] (IN1P_OFF, IN1N_OFF).
  - CH2 selected: check status bits [17:18] (IN2P_OFF, IN2N_OFF).
  - Any checked bit set: the output carries o_Z = 32'h0 instead of the sample, and an added port o_LOFF (out, 1) is 1 alongside that o_Z_STB.
  - Otherwise o_LOFF = 0.
- Undefined: port o_LOFF is absent, and samples are passed regardless of lead-off bits.

Test Plan:
- Frame C0 00 00 | 7F FF FF | 80 00 01, i_CH_SEL=0, i_Z_ACK held 1 -> o_Z = 32'h007FFFFF one cycle after byte 8; o_STATUS = 24'hC00000.
- Same frame, i_CH_SEL=1, i_Z_ACK=0 for 5 cycles -> o_Z = 32'hFF800001, held stable 5 cycles; o_Z_STB falls the cycle after the ACK.
- Two good frames, no ACK between them -> first o_Z retained; o_OVERRUN = 1; i_OVR_CLR pulse -> o_OVERRUN = 0.
- Frame with byte0 = 8'hA0 -> o_FRAME_ERR pulse, o_Z_STB stays 0. Stop after 4 bytes and wait 1024 idle cycles -> o_FRAME_ERR pulse; the next full good frame is accepted.
- Assert i_RSTN=0 after 5 bytes, release, send a full frame -> only the new frame's sample appears; no error pulse.
- With ADS1292_PACKER_LOFF_EN: status C0 80 00 (IN1P_OFF set), CH_SEL=0 -> o_Z = 0, o_LOFF = 1. CH_SEL=1 on the same frame -> CH2 sample passed, o_LOFF = 0.

Source files
------------

// File: rtl/ads1292_sample_packer.sv
// ads1292_sample_packer
// Collects the 9-byte ADS1292 read-data frame (status, CH1, CH2) from the SPI
// byte stream. It picks one channel, sign-extends the 24-bit sample to 32 bits
// and presents it on a single-entry STB/ACK output register.
// Optional feature macro: ADS1292_PACKER_LOFF_EN (lead-off masking, adds o_LOFF).
module ads1292_sample_packer #(
  parameter int unsigned BYTE_TIMEOUT = 1024,
  parameter logic [3:0]  SYNC_NIBBLE  = 4'hC
) (
  input  logic        i_CLK,
  input  logic        i_RSTN,
  input  logic [7:0]  i_BYTE,
  input  logic        i_BYTE_STB,
  input  logic        i_FRAME_START,
  input  logic        i_CH_SEL,
  input  logic        i_OVR_CLR,
  output logic [31:0] o_Z,
  output logic        o_Z_STB,
  input  logic        i_Z_ACK,
  output logic [23:0] o_STATUS,
  output logic        o_FRAME_ERR,
`ifdef ADS1292_PACKER_LOFF_EN
  output logic        o_LOFF,
`endif
  output logic        o_OVERRUN
);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(BYTE_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] tmo_q, tmo_d;
  logic [7:0]  buf_q [0:7];
  logic [7:0]  buf_d [0:7];
  logic [31:0] z_q, z_d;
  logic        z_stb_q, z_stb_d;
  logic [23:0] status_q, status_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;
`ifdef ADS1292_PACKER_LOFF_EN
  logic        loff_q, loff_d;
  logic        loff_hit_s;
`endif

  logic        complete_s;
  logic        coll_err_s;
  logic        sync_ok_s;
  logic        good_s;
  logic        slot_free_s;
  logic [23:0] status_s;
  logic [23:0] sample_s;
  logic [31:0] cand_z_s;

  // Frame collector: byte indexing, restart on a new frame start, idle timeout
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    buf_d      = buf_q;
    complete_s = 1'b0;
    coll_err_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tmo_d = 16'd0;
        if (i_BYTE_STB && i_FRAME_START) begin
          buf_d[0] = i_BYTE;
          cnt_d    = 4'd1;
          state_d  = ST_COLLECT;
        end else begin
          cnt_d = 4'd0;
        end
      end
      ST_COLLECT: begin
        if (i_BYTE_STB) begin
          tmo_d = 16'd0;
          if (i_FRAME_START) begin
            // A new frame start mid-frame aborts the old one and restarts.
            coll_err_s = 1'b1;
            buf_d[0]   = i_BYTE;
            cnt_d      = 4'd1;
          end else if (cnt_q == 4'd8) begin
            // Byte 8 is consumed straight from i_BYTE; it is never stored.
            complete_s = 1'b1;
            cnt_d      = 4'd0;
            state_d    = ST_IDLE;
          end else begin
            buf_d[cnt_q[2:0]] = i_BYTE;
            cnt_d             = cnt_q + 4'd1;
          end
        end else if (tmo_q == TMO_LAST) begin
          coll_err_s = 1'b1;
          tmo_d      = 16'd0;
          cnt_d      = 4'd0;
          state_d    = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
        tmo_d   = 16'd0;
      end
    endcase
  end

  // Completion check, channel select and single-slot output register update
  always_comb begin
    status_s    = {buf_q[0], buf_q[1], buf_q[2]};
    sample_s    = i_CH_SEL ? {buf_q[6], buf_q[7], i_BYTE} : {buf_q[3], buf_q[4], buf_q[5]};
    sync_ok_s   = (buf_q[0][7:4] == SYNC_NIBBLE);
    good_s      = complete_s && sync_ok_s;
    slot_free_s = !z_stb_q || i_Z_ACK;
`ifdef ADS1292_PACKER_LOFF_EN
    loff_hit_s  = i_CH_SEL ? (status_s[18] | status_s[17]) : (status_s[16] | status_s[15]);
    cand_z_s    = loff_hit_s ? 32'h0000_0000 : {{8{sample_s[23]}}, sample_s};
    loff_d      = loff_q;
`else
    cand_z_s    = {{8{sample_s[23]}}, sample_s};
`endif
    z_d         = z_q;
    z_stb_d     = z_stb_q;
    status_d    = status_q;
    overrun_d   = overrun_q;
    frame_err_d = coll_err_s || (complete_s && !sync_ok_s);

    if (good_s) begin
      status_d = status_s;
    end else begin
      status_d = status_q;
    end

    // An ACK on the completion cycle frees the slot for the new sample.
    if (good_s && slot_free_s) begin
      z_d     = cand_z_s;
      z_stb_d = 1'b1;
`ifdef ADS1292_PACKER_LOFF_EN
      loff_d  = loff_hit_s;
`endif
    end else if (z_stb_q && i_Z_ACK) begin
      z_stb_d = 1'b0;
    end else begin
      z_stb_d = z_stb_q;
    end

    // Clear wins over a simultaneous drop.
    if (i_OVR_CLR) begin
      overrun_d = 1'b0;
    end else if (good_s && !slot_free_s) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // State and output registers
  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      tmo_q       <= 16'd0;
      buf_q       <= '{default: 8'h00};
      z_q         <= 32'h0000_0000;
      z_stb_q     <= 1'b0;
      status_q    <= 24'h00_0000;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef ADS1292_PACKER_LOFF_EN
      loff_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      buf_q       <= buf_d;
      z_q         <= z_d;
      z_stb_q     <= z_stb_d;
      status_q    <= status_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef ADS1292_PACKER_LOFF_EN
      loff_q      <= loff_d;
`endif
    end
  end

  assign o_Z         = z_q;
  assign o_Z_STB     = z_stb_q;
  assign o_STATUS    = status_q;
  assign o_FRAME_ERR = frame_err_q;
  assign o_OVERRUN   = overrun_q;
`ifdef ADS1292_PACKER_LOFF_EN
  assign o_LOFF      = loff_q;
`endif

endmodule

// File: tb/tb_ads1292_sample_packer.sv
// Testbench for ads1292_sample_packer: directed frames feed a scoreboard queue
// of expected samples, which is popped on every output handshake.
module tb_ads1292_sample_packer;

  logic        i_CLK = 1'b0;
  logic        i_RSTN;
  logic [7:0]  i_BYTE;
  logic        i_BYTE_STB;
  logic        i_FRAME_START;
  logic        i_CH_SEL;
  logic        i_OVR_CLR;
  logic [31:0] o_Z;
  logic        o_Z_STB;
  logic        i_Z_ACK;
  logic [23:0] o_STATUS;
  logic        o_FRAME_ERR;
  logic        o_OVERRUN;
`ifdef ADS1292_PACKER_LOFF_EN
  logic        o_LOFF;
`endif

  int checks   = 0;
  int failures = 0;
  int err_cnt  = 0;
  logic [31:0] exp_q [$];

  ads1292_sample_packer dut (
    .i_CLK         (i_CLK),
    .i_RSTN        (i_RSTN),
    .i_BYTE        (i_BYTE),
    .i_BYTE_STB    (i_BYTE_STB),
    .i_FRAME_START (i_FRAME_START),
    .i_CH_SEL      (i_CH_SEL),
    .i_OVR_CLR     (i_OVR_CLR),
    .o_Z           (o_Z),
    .o_Z_STB       (o_Z_STB),
    .i_Z_ACK       (i_Z_ACK),
    .o_STATUS      (o_STATUS),
    .o_FRAME_ERR   (o_FRAME_ERR),
`ifdef ADS1292_PACKER_LOFF_EN
    .o_LOFF        (o_LOFF),
`endif
    .o_OVERRUN     (o_OVERRUN)
  );

  always #5 i_CLK = ~i_CLK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every output handshake pops one expected sample
  always @(negedge i_CLK) begin
    if (o_FRAME_ERR === 1'b1) err_cnt = err_cnt + 1;
    if (i_RSTN === 1'b1 && o_Z_STB === 1'b1 && i_Z_ACK === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_sample", o_Z, 32'hxxxx_xxxx);
      end else begin
        check_val("sb_sample", o_Z, exp_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge i_CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic fs);
    i_BYTE        = b;
    i_BYTE_STB    = 1'b1;
    i_FRAME_START = fs;
    cyc();
    i_BYTE_STB    = 1'b0;
    i_FRAME_START = 1'b0;
  endtask

  task automatic send_frame(input logic [71:0] f, input logic ch);
    logic [71:0] fr;
    fr       = f;
    i_CH_SEL = ch;
    for (int i = 0; i < 9; i++) begin
      send_byte(fr[71 - 8*i -: 8], (i == 0));
    end
  endtask

  initial begin
    int n;
    int e0;
    i_RSTN = 1'b0; i_BYTE = 8'h00; i_BYTE_STB = 1'b0; i_FRAME_START = 1'b0;
    i_CH_SEL = 1'b0; i_OVR_CLR = 1'b0; i_Z_ACK = 1'b0;
    repeat (3) cyc();
    check_val("rst_z", o_Z, 32'h0);
    check_val("rst_stb", {31'd0, o_Z_STB}, 32'd0);
    check_val("rst_status", {8'd0, o_STATUS}, 32'd0);
    check_val("rst_ferr", {31'd0, o_FRAME_ERR}, 32'd0);
    check_val("rst_ovr", {31'd0, o_OVERRUN}, 32'd0);
    i_RSTN = 1'b1;
    cyc();

    // CH1 positive full-scale, ACK held high
    i_Z_ACK = 1'b1;
    exp_q.push_back(32'h007F_FFFF);
    send_frame(72'hC0_00_00_7F_FF_FF_80_00_01, 1'b0);
    check_val("t1_stb_latency", {31'd0, o_Z_STB}, 32'd1);
    check_val("t1_z", o_Z, 32'h007F_FFFF);
    check_val("t1_status", {8'd0, o_STATUS}, 32'h00C0_0000);
    cyc();
    check_val("t1_stb_drop", {31'd0, o_Z_STB}, 32'd0);

    // CH2 negative sample, held without ACK for 5 cycles
    i_Z_ACK = 1'b0;
    exp_q.push_back(32'hFF80_0001);
    send_frame(72'hC0_00_00_7F_FF_FF_80_00_01, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check_val("t2_hold_z", o_Z, 32'hFF80_0001);
      check_val("t2_hold_stb", {31'd0, o_Z_STB}, 32'd1);
      cyc();
    end
    i_Z_ACK = 1'b1;
    cyc();
    i_Z_ACK = 1'b0;
    check_val("t2_stb_drop", {31'd0, o_Z_STB}, 32'd0);

    // Overrun: second frame dropped, status still updates
    exp_q.push_back(32'h007F_FFFF);
    send_frame(72'hC0_00_00_7F_FF_FF_80_00_01, 1'b0);
    send_frame(72'hC1_22_33_00_00_00_00_12_34, 1'b1);
    check_val("t3_z_kept", o_Z, 32'h007F_FFFF);
    check_val("t3_ovr_set", {31'd0, o_OVERRUN}, 32'd1);
    check_val("t3_status", {8'd0, o_STATUS}, 32'h00C1_2233);
    i_Z_ACK = 1'b1;
    cyc();
    i_Z_ACK = 1'b0;
    check_val("t3_ovr_sticky", {31'd0, o_OVERRUN}, 32'd1);
    i_OVR_CLR = 1'b1;
    cyc();
    i_OVR_CLR = 1'b0;
    check_val("t3_ovr_clr", {31'd0, o_OVERRUN}, 32'd0);

    // Bad sync nibble
    send_frame(72'hA0_00_00_12_34_56_00_00_01, 1'b0);
    check_val("t4_sync_err", {31'd0, o_FRAME_ERR}, 32'd1);
    check_val("t4_sync_nostb", {31'd0, o_Z_STB}, 32'd0);
    cyc();
    check_val("t4_err_pulse", {31'd0, o_FRAME_ERR}, 32'd0);

    // Frame start mid-frame restarts
    send_byte(8'hC0, 1'b1);
    send_byte(8'h00, 1'b0);
    send_byte(8'hC0, 1'b1);
    check_val("t4_restart_err", {31'd0, o_FRAME_ERR}, 32'd1);

    // Timeout after 4 bytes of a fresh frame
    cyc();
    send_byte(8'hC0, 1'b1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h12, 1'b0);
    n = 0;
    while (n < 1100 && o_FRAME_ERR !== 1'b1) begin
      cyc();
      n = n + 1;
    end
    check_val("t4_timeout_cycles", n, 32'd1024);
    i_Z_ACK = 1'b1;
    exp_q.push_back(32'h0012_3456);
    send_frame(72'hC0_00_00_12_34_56_00_00_01, 1'b0);
    check_val("t4_after_tmo_stb", {31'd0, o_Z_STB}, 32'd1);
    check_val("t4_after_tmo_z", o_Z, 32'h0012_3456);
    cyc();

    // Reset mid-frame discards partial data
    e0 = err_cnt;
    send_byte(8'hC0, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(8'h55, 1'b0);
    i_RSTN = 1'b0;
    repeat (2) cyc();
    i_RSTN = 1'b1;
    cyc();
    send_byte(8'hC0, 1'b0);
    exp_q.push_back(32'hFFFF_FFFE);
    send_frame(72'hC0_00_00_FF_FF_FE_00_00_00, 1'b0);
    check_val("t5_z", o_Z, 32'hFFFF_FFFE);
    cyc();
    check_val("t5_no_err", err_cnt - e0, 32'd0);

`ifdef ADS1292_PACKER_LOFF_EN
    exp_q.push_back(32'h0000_0000);
    send_frame(72'hC0_80_00_11_22_33_44_55_66, 1'b0);
    check_val("loff_ch1_z", o_Z, 32'h0);
    check_val("loff_ch1_flag", {31'd0, o_LOFF}, 32'd1);
    cyc();
    exp_q.push_back(32'h0044_5566);
    send_frame(72'hC0_80_00_11_22_33_44_55_66, 1'b1);
    check_val("loff_ch2_z", o_Z, 32'h0044_5566);
    check_val("loff_ch2_flag", {31'd0, o_LOFF}, 32'd0);
    cyc();
`endif

    i_Z_ACK = 1'b0;
    repeat (2) cyc();
    check_val("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
